// File: rtl/rr_req_collector_if.sv
// Bundle between the request collector and its surroundings: client pushes and
// arbiter grants in, pending-request status out.
interface rr_req_collector_if #(
  parameter int REQCNT = 16,
  parameter int PEND_W = 4
);
  localparam int IDX_W = $clog2(REQCNT);
  localparam int PMAX  = (1 << PEND_W) - 1;
  localparam int TOT_W = $clog2(REQCNT * PMAX + 1);

  logic [REQCNT-1:0] push_i;
  logic [IDX_W-1:0]  gnt_num_i;
  logic              gnt_val_i;
  logic              ovf_clr_i;
  logic [REQCNT-1:0] req_o;
  logic              req_val_o;
  logic [REQCNT-1:0] pend_full_o;
  logic [REQCNT-1:0] ovf_o;
  logic              gnt_err_o;
  logic [TOT_W-1:0]  tot_pend_o;

  modport master (
    output push_i, gnt_num_i, gnt_val_i, ovf_clr_i,
    input  req_o, req_val_o, pend_full_o, ovf_o, gnt_err_o, tot_pend_o
  );

  modport slave (
    input  push_i, gnt_num_i, gnt_val_i, ovf_clr_i,
    output req_o, req_val_o, pend_full_o, ovf_o, gnt_err_o, tot_pend_o
  );
endinterface

// File: rtl/rr_req_collector.sv
// Per-client saturating pending-request counters feeding a round-robin arbiter;
// each valid grant retires one pending request of the granted client.
module rr_req_collector #(
  parameter int REQCNT = 16,
  parameter int PEND_W = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  rr_req_collector_if.slave bus
);
  localparam int IDX_W = $clog2(REQCNT);
  localparam int PMAX  = (1 << PEND_W) - 1;
  localparam int TOT_W = $clog2(REQCNT * PMAX + 1);
  localparam logic [PEND_W-1:0] CNT_MAX = '1;

  logic [PEND_W-1:0] count_q [REQCNT];
  logic [PEND_W-1:0] count_d [REQCNT];
  logic [REQCNT-1:0] ovf_q, ovf_d;
  logic              gnt_err_q, gnt_err_d;
  logic [TOT_W-1:0]  tot_q, tot_d;

  logic [REQCNT-1:0] gnt_hit;
  logic [REQCNT-1:0] push_acc;
  logic [REQCNT-1:0] new_ovf;

  always_comb begin
    gnt_hit  = '0;
    push_acc = '0;
    new_ovf  = '0;
    for (int i = 0; i < REQCNT; i++) begin
      count_d[i]  = count_q[i];
      gnt_hit[i]  = bus.gnt_val_i && (bus.gnt_num_i == IDX_W'(i)) && (count_q[i] != '0);
      // A push paired with a hit nets to zero, so it is accepted even at PMAX.
      push_acc[i] = bus.push_i[i] && (gnt_hit[i] || (count_q[i] != CNT_MAX));
      new_ovf[i]  = bus.push_i[i] && !gnt_hit[i] && (count_q[i] == CNT_MAX);
      if (push_acc[i] && !gnt_hit[i]) begin
        count_d[i] = count_q[i] + 1'b1;
      end else if (gnt_hit[i] && !bus.push_i[i]) begin
        count_d[i] = count_q[i] - 1'b1;
      end
    end
    tot_d     = tot_q + TOT_W'($countones(push_acc)) - TOT_W'(|gnt_hit);
    ovf_d     = (bus.ovf_clr_i ? '0 : ovf_q) | new_ovf;
    // No hit on a valid grant covers both an out-of-range index and an idle client.
    gnt_err_d = bus.gnt_val_i && !(|gnt_hit);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < REQCNT; i++) begin
        count_q[i] <= '0;
      end
      ovf_q     <= '0;
      gnt_err_q <= 1'b0;
      tot_q     <= '0;
    end else begin
      for (int i = 0; i < REQCNT; i++) begin
        count_q[i] <= count_d[i];
      end
      ovf_q     <= ovf_d;
      gnt_err_q <= gnt_err_d;
      tot_q     <= tot_d;
    end
  end

  always_comb begin
    bus.req_o       = '0;
    bus.pend_full_o = '0;
    for (int i = 0; i < REQCNT; i++) begin
      bus.req_o[i]       = (count_q[i] != '0);
      bus.pend_full_o[i] = (count_q[i] == CNT_MAX);
    end
  end

  assign bus.req_val_o  = |bus.req_o;
  assign bus.ovf_o      = ovf_q;
  assign bus.gnt_err_o  = gnt_err_q;
  assign bus.tot_pend_o = tot_q;
endmodule

// File: tb/tb_rr_req_collector.sv
// Bench for rr_req_collector: directed vectors with literal checks plus a
// per-client count model compared against every output on each falling edge.
module tb_rr_req_collector;
  localparam int REQCNT = 16;
  localparam int PEND_W = 4;
  localparam int PMAX   = (1 << PEND_W) - 1;
  localparam int TOT_W  = $clog2(REQCNT * PMAX + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;

  rr_req_collector_if #(.REQCNT(REQCNT), .PEND_W(PEND_W)) bus_if ();

  rr_req_collector #(.REQCNT(REQCNT), .PEND_W(PEND_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if.slave)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: plain per-client pending counts
  int          m_cnt [REQCNT];
  logic [REQCNT-1:0] m_ovf = '0;
  logic        m_err = 1'b0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQCNT; i++) m_cnt[i] = 0;
      m_ovf  = '0;
      m_err  = 1'b0;
      chk_en = 1'b1;
    end else begin
      int hit;
      hit = -1;
      if (bus_if.gnt_val_i && int'(bus_if.gnt_num_i) < REQCNT && m_cnt[bus_if.gnt_num_i] != 0)
        hit = int'(bus_if.gnt_num_i);
      m_err = bus_if.gnt_val_i && (hit < 0);
      if (bus_if.ovf_clr_i) m_ovf = '0;
      for (int i = 0; i < REQCNT; i++) begin
        if (bus_if.push_i[i] && i != hit) begin
          if (m_cnt[i] < PMAX) m_cnt[i]++;
          else m_ovf[i] = 1'b1;
        end else if (i == hit && !bus_if.push_i[i]) begin
          m_cnt[i]--;
        end
      end
    end
  end

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      logic [REQCNT-1:0] e_req, e_full;
      int e_tot;
      e_req = '0; e_full = '0; e_tot = 0;
      for (int i = 0; i < REQCNT; i++) begin
        e_req[i]  = (m_cnt[i] != 0);
        e_full[i] = (m_cnt[i] == PMAX);
        e_tot    += m_cnt[i];
      end
      check("cmp_req",       32'(bus_if.req_o),       32'(e_req));
      check("cmp_req_val",   32'(bus_if.req_val_o),   32'(|e_req));
      check("cmp_pend_full", 32'(bus_if.pend_full_o), 32'(e_full));
      check("cmp_ovf",       32'(bus_if.ovf_o),       32'(m_ovf));
      check("cmp_gnt_err",   32'(bus_if.gnt_err_o),   32'(m_err));
      check("cmp_tot",       32'(bus_if.tot_pend_o),  32'(e_tot));
    end
  end

  // driver: hold inputs for exactly one clock edge, then return to idle
  task automatic step(input logic [REQCNT-1:0] push, input logic gv, input logic [3:0] gn,
                      input logic clr);
    bus_if.push_i    = push;
    bus_if.gnt_val_i = gv;
    bus_if.gnt_num_i = gn;
    bus_if.ovf_clr_i = clr;
    @(posedge clk);
    #1;
    bus_if.push_i    = '0;
    bus_if.gnt_val_i = 1'b0;
    bus_if.gnt_num_i = '0;
    bus_if.ovf_clr_i = 1'b0;
  endtask

  int wait_cyc [REQCNT];
  int max_wait;
  int rr_ptr;

  initial begin
    bus_if.push_i    = '1;
    bus_if.gnt_val_i = 1'b1;
    bus_if.gnt_num_i = 4'd3;
    bus_if.ovf_clr_i = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step('0, 1'b0, 4'd0, 1'b0);
    check("rst_req",  32'(bus_if.req_o), 32'h0);
    check("rst_val",  32'(bus_if.req_val_o), 32'h0);
    check("rst_tot",  32'(bus_if.tot_pend_o), 32'h0);
    check("rst_ovf",  32'(bus_if.ovf_o), 32'h0);
    check("rst_err",  32'(bus_if.gnt_err_o), 32'h0);

    // basic: three pushes then three grants to client 3
    repeat (3) step(16'h0008, 1'b0, 4'd0, 1'b0);
    check("basic_req", 32'(bus_if.req_o), 32'h0008);
    check("basic_tot", 32'(bus_if.tot_pend_o), 32'd3);
    step('0, 1'b1, 4'd3, 1'b0);
    step('0, 1'b1, 4'd3, 1'b0);
    check("basic_req_mid", 32'(bus_if.req_o), 32'h0008);
    step('0, 1'b1, 4'd3, 1'b0);
    check("basic_req_off", 32'(bus_if.req_o), 32'h0);
    check("basic_tot0",    32'(bus_if.tot_pend_o), 32'd0);

    // saturation on client 5
    repeat (16) step(16'h0020, 1'b0, 4'd0, 1'b0);
    check("sat_full", 32'(bus_if.pend_full_o), 32'h0020);
    check("sat_ovf",  32'(bus_if.ovf_o), 32'h0020);
    check("sat_tot",  32'(bus_if.tot_pend_o), 32'd15);
    step('0, 1'b0, 4'd0, 1'b1);
    check("clr_ovf",  32'(bus_if.ovf_o), 32'h0);
    check("clr_tot",  32'(bus_if.tot_pend_o), 32'd15);
    step(16'h0020, 1'b0, 4'd0, 1'b1);
    check("clr_set_wins", 32'(bus_if.ovf_o), 32'h0020);
    step('0, 1'b0, 4'd0, 1'b1);

    // simultaneous push and grant on a full client 2
    repeat (15) step(16'h0004, 1'b0, 4'd0, 1'b0);
    check("sim_pre_tot", 32'(bus_if.tot_pend_o), 32'd30);
    step(16'h0004, 1'b1, 4'd2, 1'b0);
    check("sim_ovf",  32'(bus_if.ovf_o), 32'h0);
    check("sim_full", 32'(bus_if.pend_full_o), 32'h0024);
    check("sim_tot",  32'(bus_if.tot_pend_o), 32'd30);

    // bad grant to idle client 7, then a non-valid grant
    step('0, 1'b1, 4'd7, 1'b0);
    check("bad_err",  32'(bus_if.gnt_err_o), 32'h1);
    check("bad_tot",  32'(bus_if.tot_pend_o), 32'd30);
    step('0, 1'b0, 4'd7, 1'b0);
    check("bad_err_end", 32'(bus_if.gnt_err_o), 32'h0);
    step('0, 1'b0, 4'd0, 1'b0);
    check("noval_err", 32'(bus_if.gnt_err_o), 32'h0);

    // reset discards pending requests even with a push and grant present
    bus_if.push_i = 16'hFFFF; bus_if.gnt_val_i = 1'b1; bus_if.gnt_num_i = 4'd5;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus_if.push_i = '0; bus_if.gnt_val_i = 1'b0; bus_if.gnt_num_i = '0;
    check("rst2_tot", 32'(bus_if.tot_pend_o), 32'd0);
    check("rst2_req", 32'(bus_if.req_o), 32'h0);

    // closed loop: clients 8..15 push every cycle, round-robin grants from req_o
    for (int i = 0; i < REQCNT; i++) wait_cyc[i] = 0;
    max_wait = 0;
    rr_ptr   = 0;
    for (int c = 0; c < 200; c++) begin
      int g;
      g = -1;
      for (int k = 1; k <= REQCNT; k++) begin
        int j;
        j = (rr_ptr + k) % REQCNT;
        if (g < 0 && bus_if.req_o[j]) g = j;
      end
      for (int i = 0; i < REQCNT; i++) begin
        if (bus_if.req_o[i] && i != g) wait_cyc[i]++;
        else wait_cyc[i] = 0;
        if (wait_cyc[i] > max_wait) max_wait = wait_cyc[i];
      end
      if (g >= 0) rr_ptr = g;
      step(16'hFF00, g >= 0, (g >= 0) ? 4'(g) : 4'd0, 1'b0);
    end
    check("loop_latency", 32'(max_wait <= 8), 32'h1);
    check("loop_req", 32'(bus_if.req_o), 32'hFF00);

    step('0, 1'b0, 4'd0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
